// File: rtl/gopf_eval_horner.sv
// Goppa-polynomial evaluator: Horner's rule over LANES points through an external MAC array.
// Optional macro GOPF_EVAL_ROOT_FLAG_EN adds per-lane zero-result flags on eval_root.
module gopf_eval_horner #(
    parameter int GF_W  = 16,
    parameter int LANES = 9,
    parameter int DEG   = 8,
    parameter int CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    start,
    input  logic [(DEG+1)*GF_W-1:0] gopf,
    input  logic [LANES*GF_W-1:0]   gf2e_element,
    output logic                    busy,
    output logic                    eval_done,
    output logic [LANES*GF_W-1:0]   eval_r_dat,
    output logic [LANES-1:0]        eval_root,
    output logic [LANES*GF_W-1:0]   mul_o_out,
    output logic [LANES*GF_W-1:0]   mul_t_out,
    output logic [LANES*GF_W-1:0]   mul_add_out,
    input  logic [LANES*GF_W-1:0]   mul_r_dat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [GF_W-1:0]        coef [DEG+1];
    logic [LANES*GF_W-1:0]  mul_o;
    logic [LANES*GF_W-1:0]  acc;
    logic [GF_W-1:0]        mul_add;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_m1;

    assign cnt_m1 = cnt - 1'b1;

    // Each step costs a CAPT plus an ISSUE settle cycle so the MAC path gets a full cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            busy      <= 1'b0;
            eval_done <= 1'b0;
            mul_o     <= '0;
            acc       <= '0;
            mul_add   <= '0;
            cnt       <= '0;
            for (int i = 0; i <= DEG; i++) begin
                coef[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i <= DEG; i++) begin
                            coef[i] <= gopf[i*GF_W +: GF_W];
                        end
                        mul_o   <= gf2e_element;
                        acc     <= '0;
                        mul_add <= gopf[DEG*GF_W +: GF_W];
                        cnt     <= CNT_W'(DEG);
                        busy    <= 1'b1;
                        state   <= CAPT;
                    end
                end
                CAPT: begin
                    acc <= mul_r_dat;
                    if (cnt == '0) begin
                        busy      <= 1'b0;
                        eval_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mul_add <= coef[cnt_m1];
                        cnt     <= cnt_m1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPT;
                end
                DONE: begin
                    eval_done <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign eval_r_dat  = acc;
    assign mul_t_out   = acc;
    assign mul_o_out   = mul_o;
    assign mul_add_out = {LANES{mul_add}};

`ifdef GOPF_EVAL_ROOT_FLAG_EN
    logic [LANES-1:0] root_r;

    // Flags are taken from the final MAC result, the same value that lands in acc.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            root_r <= '0;
        end else if (state == IDLE && start) begin
            root_r <= '0;
        end else if (state == CAPT && cnt == '0) begin
            for (int j = 0; j < LANES; j++) begin
                root_r[j] <= (mul_r_dat[j*GF_W +: GF_W] == '0);
            end
        end
    end

    assign eval_root = root_r;
`else
    assign eval_root = '0;
`endif

endmodule
